// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one integer ALU between N_REQ requesters (execute stage, AMO unit,
// address generation, ...). Requests are picked round-robin, the chosen
// operands go through a single combinational ALU, and the result sits in one
// registered output stage until its owner takes it.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    request present, one bit per requester
//   o_req_ready    request accepted this cycle (one-hot or zero)
//   i_req_in1      operand 1 per requester (64 bit)
//   i_req_in2      operand 2 per requester (64 bit)
//   i_req_is_word  1: 32-bit operation, result sign-extended to 64 bit
//   i_req_op       ALU operation per requester
//   o_resp_valid   held result belongs to requester i (at most one bit set)
//   i_resp_ready   requester i consumes its result
//   o_resp_data    result of the held operation
//
// Also contains the ALU operation package and the ALU itself, so the block
// can be dropped into a project as a single file.
// -----------------------------------------------------------------------------

package alu_arbiter_pkg;
    // Encodings 10..15 are undefined and make the ALU return zero.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;
endpackage

// Combinational 64-bit integer ALU with 32-bit "word" variants.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [63:0] i_in1,
    input  logic [63:0] i_in2,
    input  logic        i_isWord,
    input  alu_op_e     i_op,
    output logic [63:0] o_result
);

    logic [31:0] w_a32;
    logic [31:0] w_b32;
    logic [63:0] w_res64;
    logic [31:0] w_res32;

    assign w_a32 = i_in1[31:0];
    assign w_b32 = i_in2[31:0];

    // Both the full-width and the word result are computed side by side; the
    // word flavour only looks at the low operand halves and shifts by 5 bits.
    always_comb begin
        w_res64 = '0;
        w_res32 = '0;
        case (i_op)
            ALU_ADD: begin
                w_res64 = i_in1 + i_in2;
                w_res32 = w_a32 + w_b32;
            end
            ALU_SUB: begin
                w_res64 = i_in1 - i_in2;
                w_res32 = w_a32 - w_b32;
            end
            ALU_SLL: begin
                w_res64 = i_in1 << i_in2[5:0];
                w_res32 = w_a32 << i_in2[4:0];
            end
            ALU_SLT: begin
                w_res64 = {63'd0, $signed(i_in1) < $signed(i_in2)};
                w_res32 = {31'd0, $signed(w_a32) < $signed(w_b32)};
            end
            ALU_SLTU: begin
                w_res64 = {63'd0, i_in1 < i_in2};
                w_res32 = {31'd0, w_a32 < w_b32};
            end
            ALU_XOR: begin
                w_res64 = i_in1 ^ i_in2;
                w_res32 = w_a32 ^ w_b32;
            end
            ALU_SRL: begin
                w_res64 = i_in1 >> i_in2[5:0];
                w_res32 = w_a32 >> i_in2[4:0];
            end
            ALU_SRA: begin
                w_res64 = $unsigned($signed(i_in1) >>> i_in2[5:0]);
                w_res32 = $unsigned($signed(w_a32) >>> i_in2[4:0]);
            end
            ALU_OR: begin
                w_res64 = i_in1 | i_in2;
                w_res32 = w_a32 | w_b32;
            end
            ALU_AND: begin
                w_res64 = i_in1 & i_in2;
                w_res32 = w_a32 & w_b32;
            end
            default: begin
                w_res64 = '0;
                w_res32 = '0;
            end
        endcase
    end

    assign o_result = i_isWord ? {{32{w_res32[31]}}, w_res32} : w_res64;

endmodule

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic [N_REQ-1:0][63:0]  i_req_in1,
    input  logic [N_REQ-1:0][63:0]  i_req_in2,
    input  logic [N_REQ-1:0]        i_req_is_word,
    input  alu_op_e [N_REQ-1:0]     i_req_op,
    output logic [N_REQ-1:0]        o_resp_valid,
    input  logic [N_REQ-1:0]        i_resp_ready,
    output logic [63:0]             o_resp_data
);

    localparam int               ID_W   = $clog2(N_REQ);
    localparam logic [ID_W:0]    NREQ_W = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

    logic             r_vld;
    logic [ID_W-1:0]  r_owner;
    logic [63:0]      r_data;
    logic [ID_W-1:0]  r_rrPtr;

    logic             w_anyValid;
    logic [ID_W-1:0]  w_win;
    logic [ID_W:0]    w_scanSum;
    logic [ID_W-1:0]  w_scanIdx;
    logic             w_canAccept;
    logic             w_accept;
    logic [ID_W-1:0]  w_nextPtr;
    logic [63:0]      w_aluOut;

    // Round-robin scan starting at the pointer; the first valid requester
    // found wins. The sum is one bit wider so the wrap can be done with a
    // single subtract instead of a modulo.
    always_comb begin
        w_anyValid = 1'b0;
        w_win      = '0;
        w_scanSum  = '0;
        w_scanIdx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scanSum = {1'b0, r_rrPtr} + (ID_W + 1)'(k);
            if (w_scanSum >= NREQ_W) begin
                w_scanSum = w_scanSum - NREQ_W;
            end
            w_scanIdx = w_scanSum[ID_W-1:0];
            if (!w_anyValid && i_req_valid[w_scanIdx]) begin
                w_anyValid = 1'b1;
                w_win      = w_scanIdx;
            end
        end
    end

    // The output register can take a new result when it is empty or its
    // owner is draining it this cycle. Only the owner's resp_ready counts,
    // so losers can never influence req_ready. Reset gates acceptance so no
    // handshake is offered while the block is held in reset.
    assign w_canAccept = !r_vld || i_resp_ready[r_owner];
    assign w_accept    = w_anyValid && w_canAccept && i_rst_n;
    assign w_nextPtr   = (w_win == LAST_ID) ? '0 : w_win + 1'b1;

    always_comb begin
        o_req_ready = '0;
        if (w_accept) begin
            o_req_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        o_resp_valid = '0;
        if (r_vld) begin
            o_resp_valid[r_owner] = 1'b1;
        end
    end

    alu u_alu (
        .i_in1    (i_req_in1[w_win]),
        .i_in2    (i_req_in2[w_win]),
        .i_isWord (i_req_is_word[w_win]),
        .i_op     (i_req_op[w_win]),
        .o_result (w_aluOut)
    );

    // Single result stage. An accept always overwrites (covers the
    // drain-and-accept case without a bubble); a plain drain only clears the
    // valid flag so resp_data keeps its last value. During a stall nothing
    // changes, including the round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld   <= 1'b0;
            r_owner <= '0;
            r_data  <= '0;
            r_rrPtr <= '0;
        end else if (w_accept) begin
            r_vld   <= 1'b1;
            r_owner <= w_win;
            r_data  <= w_aluOut;
            r_rrPtr <= w_nextPtr;
        end else if (r_vld && i_resp_ready[r_owner]) begin
            r_vld <= 1'b0;
        end
    end

    assign o_resp_data = r_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter with two requesters. Every accepted
// request is modelled independently and queued; results are compared as the
// DUT presents them. Inputs change 1 time unit after a rising edge, outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              rstN;
    logic [1:0]        reqValid;
    logic [1:0]        reqReady;
    logic [1:0][63:0]  reqIn1;
    logic [1:0][63:0]  reqIn2;
    logic [1:0]        reqIsWord;
    alu_op_e [1:0]     reqOp;
    logic [1:0]        respValid;
    logic [1:0]        respReady;
    logic [63:0]       respData;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        int          owner;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(2)) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_req_valid   (reqValid),
        .o_req_ready   (reqReady),
        .i_req_in1     (reqIn1),
        .i_req_in2     (reqIn2),
        .i_req_is_word (reqIsWord),
        .i_req_op      (reqOp),
        .o_resp_valid  (respValid),
        .i_resp_ready  (respReady),
        .o_resp_data   (respData)
    );

    // Reference ALU written from the operation definitions.
    function automatic logic [63:0] modelAlu(input logic [63:0] a, input logic [63:0] b,
                                             input logic w, input logic [3:0] op);
        logic [31:0] a32;
        logic [31:0] b32;
        logic [31:0] rw;
        logic [63:0] r;
        logic [5:0]  sh;
        a32 = a[31:0];
        b32 = b[31:0];
        rw  = 32'd0;
        r   = 64'd0;
        sh  = b[5:0];
        if (w) begin
            case (op)
                4'd0: rw = a32 + b32;
                4'd1: rw = a32 - b32;
                4'd2: rw = a32 << b[4:0];
                4'd3: rw = ($signed(a32) < $signed(b32)) ? 32'd1 : 32'd0;
                4'd4: rw = (a32 < b32) ? 32'd1 : 32'd0;
                4'd5: rw = a32 ^ b32;
                4'd6: rw = a32 >> b[4:0];
                4'd7: rw = (a32 >> b[4:0]) | (a32[31] ? ~(32'hFFFF_FFFF >> b[4:0]) : 32'd0);
                4'd8: rw = a32 | b32;
                4'd9: rw = a32 & b32;
                default: return 64'd0;
            endcase
            return {{32{rw[31]}}, rw};
        end
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a << sh;
            4'd3: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd4: r = (a < b) ? 64'd1 : 64'd0;
            4'd5: r = a ^ b;
            4'd6: r = a >> sh;
            4'd7: r = (a >> sh) | (a[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> sh) : 64'd0);
            4'd8: r = a | b;
            4'd9: r = a & b;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Loads a payload for one requester; seq selects operation and operands.
    task automatic applyStimulus(input int idx, input int seq);
        logic [3:0] opCode;
        case (seq % 11)
            0: opCode = 4'd0;
            1: opCode = 4'd1;
            2: opCode = 4'd5;
            3: opCode = 4'd7;
            4: opCode = 4'd4;
            5: opCode = 4'd9;
            6: opCode = 4'd8;
            7: opCode = 4'd6;
            8: opCode = 4'd3;
            9: opCode = 4'd2;
            default: opCode = 4'd15;
        endcase
        reqIn1[idx]    = 64'hF234_5678_9ABC_DEF0 ^ (64'(seq) * 64'h0101_0101_0101_0101);
        reqIn2[idx]    = 64'(seq * 7 + 3) | (seq[1] ? 64'h8000_0000_0000_0000 : 64'd0);
        reqIsWord[idx] = seq[0];
        reqOp[idx]     = alu_op_e'(opCode);
    endtask

    // Records any handshake seen this cycle into the scoreboard, then moves
    // to just after the next rising edge.
    task automatic advance();
        for (int i = 0; i < 2; i++) begin
            if (reqValid[i] && reqReady[i]) begin
                sb.push_back('{owner: i,
                               data: modelAlu(reqIn1[i], reqIn2[i], reqIsWord[i], reqOp[i])});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN      = 1'b0;
        reqValid  = 2'b11;
        respReady = 2'b00;
        applyStimulus(0, 0);
        applyStimulus(1, 1);
        #3;
        checkCount++;
        if (reqReady !== 2'b00) $display("[TB] FAIL reset_req_ready: got %b expected 00", reqReady);
        else passCount++;
        checkCount++;
        if (respValid !== 2'b00) $display("[TB] FAIL reset_resp_valid: got %b expected 00", respValid);
        else passCount++;
        checkCount++;
        if (respData !== 64'd0) $display("[TB] FAIL reset_resp_data: got %h expected 0", respData);
        else passCount++;
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkCount++;
        if (reqReady !== 2'b01) $display("[TB] FAIL reset_release_grant: got %b expected 01", reqReady);
        else passCount++;
        reqValid = 2'b00;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_op();
        exp_t e;
        respReady   = 2'b01;
        reqIn1[0]   = 64'd5;
        reqIn2[0]   = -64'sd3;
        reqIsWord[0] = 1'b0;
        reqOp[0]    = ALU_ADD;
        reqValid    = 2'b01;
        @(negedge clk);
        checkCount++;
        if (reqReady !== 2'b01) $display("[TB] FAIL single_req_ready: got %b expected 01", reqReady);
        else passCount++;
        advance();
        reqValid = 2'b00;
        @(negedge clk);
        checkCount++;
        if (sb.size() == 0) $display("[TB] FAIL single_result: got nothing queued expected one result");
        else begin
            e = sb.pop_front();
            if (respValid !== (2'b01 << e.owner) || respData !== e.data || respData !== 64'd2)
                $display("[TB] FAIL single_result: got valid=%b data=%h expected valid=%b data=%h",
                         respValid, respData, 2'b01 << e.owner, e.data);
            else passCount++;
        end
        advance();
        @(negedge clk);
        checkCount++;
        if (respValid !== 2'b00 || respData !== 64'd2)
            $display("[TB] FAIL single_drain: got valid=%b data=%h expected valid=00 data=2",
                     respValid, respData);
        else passCount++;
        advance();
    endtask

    task automatic test_word_op();
        exp_t e;
        respReady    = 2'b10;
        reqIn1[1]    = 64'h1;
        reqIn2[1]    = 64'd31;
        reqIsWord[1] = 1'b1;
        reqOp[1]     = ALU_SLL;
        reqValid     = 2'b10;
        @(negedge clk);
        checkCount++;
        if (reqReady !== 2'b10) $display("[TB] FAIL word_req_ready: got %b expected 10", reqReady);
        else passCount++;
        advance();
        reqValid = 2'b00;
        @(negedge clk);
        checkCount++;
        if (sb.size() == 0) $display("[TB] FAIL word_result: got nothing queued expected one result");
        else begin
            e = sb.pop_front();
            if (respValid !== 2'b10 || e.owner != 1 || respData !== e.data ||
                respData !== 64'hFFFF_FFFF_8000_0000)
                $display("[TB] FAIL word_result: got valid=%b data=%h expected valid=10 data=%h",
                         respValid, respData, e.data);
            else passCount++;
        end
        advance();
    endtask

    task automatic test_round_robin();
        exp_t e;
        int expGrant;
        int prevGrant;
        int seq;
        respReady = 2'b11;
        seq       = 2;
        applyStimulus(0, seq++);
        applyStimulus(1, seq++);
        reqValid  = 2'b11;
        expGrant  = 0;
        prevGrant = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkCount++;
            if (reqReady !== (2'b01 << expGrant))
                $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, reqReady, 2'b01 << expGrant);
            else passCount++;
            if (k > 0) begin
                checkCount++;
                if (sb.size() == 0) $display("[TB] FAIL rr_result_%0d: got nothing queued", k);
                else begin
                    e = sb.pop_front();
                    if (respValid !== (2'b01 << prevGrant) || respData !== e.data)
                        $display("[TB] FAIL rr_result_%0d: got valid=%b data=%h expected valid=%b data=%h",
                                 k, respValid, respData, 2'b01 << prevGrant, e.data);
                    else passCount++;
                end
            end
            advance();
            applyStimulus(expGrant, seq++);
            prevGrant = expGrant;
            expGrant  = 1 - expGrant;
        end
        reqValid = 2'b00;
        @(negedge clk);
        checkCount++;
        if (sb.size() == 0) $display("[TB] FAIL rr_last_result: got nothing queued");
        else begin
            e = sb.pop_front();
            if (respValid !== (2'b01 << prevGrant) || respData !== e.data)
                $display("[TB] FAIL rr_last_result: got valid=%b data=%h expected valid=%b data=%h",
                         respValid, respData, 2'b01 << prevGrant, e.data);
            else passCount++;
        end
        advance();
    endtask

    task automatic test_backpressure();
        exp_t e;
        respReady = 2'b00;
        applyStimulus(0, 20);
        reqValid = 2'b01;
        @(negedge clk);
        checkCount++;
        if (reqReady !== 2'b01) $display("[TB] FAIL bp_first_accept: got %b expected 01", reqReady);
        else passCount++;
        advance();
        applyStimulus(1, 21);
        reqValid = 2'b10;
        for (int c = 0; c < 3; c++) begin
            respReady = (c == 1) ? 2'b10 : 2'b00;
            @(negedge clk);
            checkCount++;
            if (reqReady !== 2'b00) $display("[TB] FAIL bp_stall_ready_%0d: got %b expected 00", c, reqReady);
            else passCount++;
            checkCount++;
            if (sb.size() == 0) $display("[TB] FAIL bp_stall_hold_%0d: got nothing queued", c);
            else if (respValid !== 2'b01 || respData !== sb[0].data)
                $display("[TB] FAIL bp_stall_hold_%0d: got valid=%b data=%h expected valid=01 data=%h",
                         c, respValid, respData, sb[0].data);
            else passCount++;
            advance();
        end
        respReady = 2'b01;
        @(negedge clk);
        checkCount++;
        if (reqReady !== 2'b10) $display("[TB] FAIL bp_drain_accept: got %b expected 10", reqReady);
        else passCount++;
        checkCount++;
        if (sb.size() == 0) $display("[TB] FAIL bp_held_result: got nothing queued");
        else begin
            e = sb.pop_front();
            if (respValid !== 2'b01 || respData !== e.data)
                $display("[TB] FAIL bp_held_result: got valid=%b data=%h expected valid=01 data=%h",
                         respValid, respData, e.data);
            else passCount++;
        end
        advance();
        reqValid = 2'b00;
        @(negedge clk);
        checkCount++;
        if (sb.size() == 0) $display("[TB] FAIL bp_next_result: got nothing queued");
        else begin
            e = sb.pop_front();
            if (respValid !== 2'b10 || respData !== e.data)
                $display("[TB] FAIL bp_next_result: got valid=%b data=%h expected valid=10 data=%h",
                         respValid, respData, e.data);
            else passCount++;
        end
        respReady = 2'b11;
        advance();
    endtask

    task automatic test_async_reset();
        respReady = 2'b00;
        applyStimulus(0, 30);
        reqValid = 2'b01;
        @(negedge clk);
        checkCount++;
        if (reqReady !== 2'b01) $display("[TB] FAIL ar_accept: got %b expected 01", reqReady);
        else passCount++;
        advance();
        reqValid = 2'b00;
        @(negedge clk);
        checkCount++;
        if (respValid !== 2'b01) $display("[TB] FAIL ar_before: got %b expected 01", respValid);
        else passCount++;
        #2;
        rstN     = 1'b0;
        reqValid = 2'b01;
        #1;
        checkCount++;
        if (respValid !== 2'b00 || respData !== 64'd0 || reqReady !== 2'b00)
            $display("[TB] FAIL ar_immediate: got valid=%b data=%h ready=%b expected valid=00 data=0 ready=00",
                     respValid, respData, reqReady);
        else passCount++;
        sb.delete();
        reqValid = 2'b11;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
        checkCount++;
        if (reqReady !== 2'b01) $display("[TB] FAIL ar_ptr_reset: got %b expected 01", reqReady);
        else passCount++;
        reqValid = 2'b00;
        advance();
    endtask

    initial begin
        reqIn1    = '0;
        reqIn2    = '0;
        reqIsWord = '0;
        reqOp     = {ALU_ADD, ALU_ADD};
        test_reset();
        test_single_op();
        test_word_op();
        test_round_robin();
        test_backpressure();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
